// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller.
// Drives external tag/data memories (combinational read) and a 128-bit block memory port.
module cache_ctrl_fsm #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 19,
  parameter int IDX_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_valid_i,
  input  logic              cpu_rw_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_ready_o,
  output logic              mem_valid_o,
  output logic              mem_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [127:0]      mem_data_o,
  input  logic [127:0]      mem_data_i,
  input  logic              mem_ready_i,
  output logic [IDX_W-1:0]  tag_index_o,
  output logic              tag_we_o,
  output logic [TAG_W+1:0]  tag_write_o,
  input  logic [TAG_W+1:0]  tag_read_i,
  output logic [IDX_W-1:0]  data_index_o,
  output logic              data_we_o,
  output logic [127:0]      data_write_o,
  input  logic [127:0]      data_read_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t            state_reg;
  logic [TAG_W-1:0]  req_tag_reg;
  logic [IDX_W-1:0]  req_idx_reg;
  logic [1:0]        req_word_reg;
  logic [31:0]       req_data_reg;
  logic              req_rw_reg;
  logic              refill_reg;

  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic              hit;
  logic [31:0]       read_word;
  logic [127:0]      merged_block;
  logic              unused_addr;

  assign unused_addr  = ^cpu_addr_i[1:0];

  assign tag_index_o  = req_idx_reg;
  assign data_index_o = req_idx_reg;

  assign line_valid = tag_read_i[TAG_W+1];
  assign line_dirty = tag_read_i[TAG_W];
  assign line_tag   = tag_read_i[TAG_W-1:0];
  assign hit        = line_valid && (line_tag == req_tag_reg);
  assign read_word  = data_read_i[{req_word_reg, 5'b00000} +: 32];

  // Write-hit block: the addressed word replaced by the CPU data, the rest kept
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_block[32*gi +: 32] = (req_word_reg == 2'(gi)) ? req_data_reg
                                                               : data_read_i[32*gi +: 32];
  end

  // Memory-array writes must land on the edge that ends the deciding cycle
  always_comb begin
    tag_we_o     = 1'b0;
    tag_write_o  = '0;
    data_we_o    = 1'b0;
    data_write_o = '0;
    case (state_reg)
      COMPARE: begin
        if (hit && req_rw_reg) begin
          data_we_o    = 1'b1;
          data_write_o = merged_block;
          tag_we_o     = 1'b1;
          tag_write_o  = {1'b1, 1'b1, req_tag_reg};
        end
      end
      ALLOCATE: begin
        if (mem_valid_o && mem_ready_i) begin
          data_we_o    = 1'b1;
          data_write_o = mem_data_i;
          tag_we_o     = 1'b1;
          tag_write_o  = {1'b1, 1'b0, req_tag_reg};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      req_tag_reg  <= '0;
      req_idx_reg  <= '0;
      req_word_reg <= '0;
      req_data_reg <= '0;
      req_rw_reg   <= 1'b0;
      refill_reg   <= 1'b0;
      cpu_ready_o  <= 1'b0;
      cpu_data_o   <= '0;
      mem_valid_o  <= 1'b0;
      mem_rw_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
    end else begin
      cpu_ready_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_valid_i) begin
            req_tag_reg  <= cpu_addr_i[ADDR_W-1 -: TAG_W];
            req_idx_reg  <= cpu_addr_i[4 +: IDX_W];
            req_word_reg <= cpu_addr_i[3:2];
            req_data_reg <= cpu_data_i;
            req_rw_reg   <= cpu_rw_i;
            refill_reg   <= 1'b0;
            state_reg    <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            // The guaranteed hit after a refill is not a first-lookup hit
            if (!refill_reg) begin
              hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (!req_rw_reg) begin
              cpu_data_o <= read_word;
            end
            cpu_ready_o <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            miss_cnt_o  <= miss_cnt_o + 32'd1;
            mem_valid_o <= 1'b1;
            if (line_valid && line_dirty) begin
              mem_rw_o   <= 1'b1;
              mem_addr_o <= {line_tag, req_idx_reg, 4'b0000};
              mem_data_o <= data_read_i;
              state_reg  <= WRITE_BACK;
            end else begin
              mem_rw_o   <= 1'b0;
              mem_addr_o <= {req_tag_reg, req_idx_reg, 4'b0000};
              state_reg  <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          // Chain straight into the fill request; the address/rw change marks the new transfer
          if (mem_ready_i) begin
            mem_rw_o   <= 1'b0;
            mem_addr_o <= {req_tag_reg, req_idx_reg, 4'b0000};
            state_reg  <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            refill_reg  <= 1'b1;
            state_reg   <= COMPARE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm: behavioural tag/data arrays plus a main-memory
// responder with configurable wait, checked against hand-computed values.
module tb_cache_ctrl_fsm;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         cpu_valid_i = 1'b0;
  logic         cpu_rw_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_ready_o;
  logic         mem_valid_o;
  logic         mem_rw_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i = '0;
  logic         mem_ready_i = 1'b0;
  logic [8:0]   tag_index_o;
  logic         tag_we_o;
  logic [20:0]  tag_write_o;
  logic [20:0]  tag_read_i;
  logic [8:0]   data_index_o;
  logic         data_we_o;
  logic [127:0] data_write_o;
  logic [127:0] data_read_i;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  cache_ctrl_fsm dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_valid_i  (cpu_valid_i),
    .cpu_rw_i     (cpu_rw_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_ready_o  (cpu_ready_o),
    .mem_valid_o  (mem_valid_o),
    .mem_rw_o     (mem_rw_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ready_i  (mem_ready_i),
    .tag_index_o  (tag_index_o),
    .tag_we_o     (tag_we_o),
    .tag_write_o  (tag_write_o),
    .tag_read_i   (tag_read_i),
    .data_index_o (data_index_o),
    .data_we_o    (data_we_o),
    .data_write_o (data_write_o),
    .data_read_i  (data_read_i),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Tag and data arrays: combinational read, synchronous write
  logic [20:0]  tag_mem  [512];
  logic [127:0] data_mem [512];

  assign tag_read_i  = tag_mem[tag_index_o];
  assign data_read_i = data_mem[data_index_o];

  always @(posedge clk_i) begin
    if (tag_we_o)  tag_mem[tag_index_o]   <= tag_write_o;
    if (data_we_o) data_mem[data_index_o] <= data_write_o;
  end

  typedef struct packed {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } txn_t;

  logic [127:0] main_mem [int unsigned];
  txn_t         txn_q [$];
  int           mem_wait = 0;
  int           stall = 0;

  // Main memory: raises ready after mem_wait idle cycles of a pending request
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mem_ready_i = 1'b0;
      stall = 0;
    end else if (mem_ready_i) begin
      mem_ready_i = 1'b0;
      stall = 0;
    end else if (mem_valid_o) begin
      if (stall >= mem_wait) begin
        txn_t t;
        t.rw = mem_rw_o;
        t.addr = mem_addr_o;
        t.data = mem_data_o;
        txn_q.push_back(t);
        if (mem_rw_o) main_mem[mem_addr_o] = mem_data_o;
        else mem_data_i = main_mem.exists(mem_addr_o) ? main_mem[mem_addr_o] : '0;
        mem_ready_i = 1'b1;
      end else begin
        stall++;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    cpu_valid_i = 1'b1;
    cpu_rw_i    = rw;
    cpu_addr_i  = addr;
    cpu_data_i  = data;
    @(negedge clk_i);
    cpu_valid_i = 1'b0;
  endtask

  // Called one negedge after valid was raised; lat counts cycles from valid
  task automatic wait_ready(input logic [31:0] addr, output int lat);
    lat = 1;
    while (!cpu_ready_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    chk("ready_seen", cpu_ready_o, 1'b1);
    $display("txn addr=%08h data=%08h lat=%0d hits=%0d misses=%0d",
             addr, cpu_data_o, lat, hit_cnt_o, miss_cnt_o);
  endtask

  task automatic wait_mem_valid(input string tag);
    int n;
    n = 0;
    while (!mem_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, mem_valid_o, 1'b1);
  endtask

  localparam logic [127:0] BLK_1000 = 128'h33333333_DEADBEEF_11111111_A0A0A0A0;
  localparam logic [127:0] BLK_MOD  = 128'h33333333_DEADBEEF_12345678_A0A0A0A0;
  localparam logic [127:0] BLK_3000 = 128'hC3C3C3C3_CAFEF00D_C1C1C1C1_C0C0C0C0;

  initial begin
    int lat;
    for (int i = 0; i < 512; i++) begin
      tag_mem[i]  <= '0;
      data_mem[i] <= '0;
    end
    main_mem[32'h0000_1000] = BLK_1000;
    main_mem[32'h0000_3000] = BLK_3000;

    repeat (3) @(negedge clk_i);
    chk("rst_ready", cpu_ready_o, 1'b0);
    chk("rst_data", cpu_data_o, 32'h0);
    chk("rst_mem_valid", mem_valid_o, 1'b0);
    chk("rst_hits", hit_cnt_o, 32'h0);
    chk("rst_misses", miss_cnt_o, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Cold read miss, zero-wait fill
    issue(1'b0, 32'h0000_1008, 32'h0);
    wait_ready(32'h0000_1008, lat);
    chk("cold_lat", lat, 4);
    chk("cold_data", cpu_data_o, 32'hDEADBEEF);
    chk("cold_misses", miss_cnt_o, 32'd1);
    chk("cold_hits", hit_cnt_o, 32'd0);
    chk("cold_txn_cnt", txn_q.size(), 1);
    chk("cold_fill_addr", txn_q[0].addr, 32'h0000_1000);
    chk("cold_fill_rw", txn_q[0].rw, 1'b0);
    chk("cold_tag", tag_mem[9'h100], 21'h100000);

    // Repeat read hits
    @(negedge clk_i);
    issue(1'b0, 32'h0000_1008, 32'h0);
    wait_ready(32'h0000_1008, lat);
    chk("hit_lat", lat, 2);
    chk("hit_data", cpu_data_o, 32'hDEADBEEF);
    chk("hit_hits", hit_cnt_o, 32'd1);
    chk("hit_txn_cnt", txn_q.size(), 1);

    // Write hit: merged block and dirty tag presented during the compare cycle
    @(negedge clk_i);
    issue(1'b1, 32'h0000_1004, 32'h12345678);
    chk("wr_data_we", data_we_o, 1'b1);
    chk("wr_data_write", data_write_o, BLK_MOD);
    chk("wr_tag_we", tag_we_o, 1'b1);
    chk("wr_tag_write", tag_write_o, 21'h180000);
    wait_ready(32'h0000_1004, lat);
    chk("wr_lat", lat, 2);
    chk("wr_hits", hit_cnt_o, 32'd2);

    // Dirty conflict miss with a 10-cycle stall on the write-back
    mem_wait = 10;
    @(negedge clk_i);
    issue(1'b0, 32'h0000_3008, 32'h0);
    wait_mem_valid("wb_req_seen");
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", mem_valid_o, 1'b1);
      chk("stall_rw", mem_rw_o, 1'b1);
      chk("stall_addr", mem_addr_o, 32'h0000_1000);
      chk("stall_data", mem_data_o, BLK_MOD);
      if (i == 3) begin
        cpu_valid_i = 1'b1;
        cpu_rw_i    = 1'b1;
        cpu_addr_i  = 32'h0000_5000;
      end
      if (i == 4) cpu_valid_i = 1'b0;
      @(negedge clk_i);
    end
    wait_ready(32'h0000_3008, lat);
    chk("dirty_data", cpu_data_o, 32'hCAFEF00D);
    chk("dirty_misses", miss_cnt_o, 32'd2);
    chk("dirty_hits", hit_cnt_o, 32'd2);
    chk("dirty_txn_cnt", txn_q.size(), 3);
    chk("dirty_wb_rw", txn_q[1].rw, 1'b1);
    chk("dirty_wb_addr", txn_q[1].addr, 32'h0000_1000);
    chk("dirty_wb_data", txn_q[1].data, BLK_MOD);
    chk("dirty_fill_rw", txn_q[2].rw, 1'b0);
    chk("dirty_fill_addr", txn_q[2].addr, 32'h0000_3000);
    chk("dirty_tag", tag_mem[9'h100], 21'h100001);
    repeat (3) begin
      @(negedge clk_i);
      chk("post_stall_idle", {mem_valid_o, cpu_ready_o}, 2'b00);
    end
    chk("post_stall_txn_cnt", txn_q.size(), 3);

    // Clean miss refetches the written-back block
    mem_wait = 0;
    issue(1'b0, 32'h0000_1004, 32'h0);
    wait_ready(32'h0000_1004, lat);
    chk("refetch_lat", lat, 4);
    chk("refetch_data", cpu_data_o, 32'h12345678);
    chk("refetch_misses", miss_cnt_o, 32'd3);
    chk("refetch_txn_cnt", txn_q.size(), 4);

    // Asynchronous reset in the middle of a fill
    mem_wait = 1000;
    @(negedge clk_i);
    issue(1'b0, 32'h0000_0020, 32'h0);
    wait_mem_valid("alloc_req_seen");
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_mem_valid", mem_valid_o, 1'b0);
    chk("arst_ready", cpu_ready_o, 1'b0);
    chk("arst_hits", hit_cnt_o, 32'd0);
    chk("arst_misses", miss_cnt_o, 32'd0);
    chk("arst_data", cpu_data_o, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_wait = 0;
    repeat (4) begin
      @(negedge clk_i);
      chk("arst_idle", {mem_valid_o, cpu_ready_o}, 2'b00);
    end

    // Arrays survive reset, so the resident line hits straight from idle
    issue(1'b0, 32'h0000_1008, 32'h0);
    wait_ready(32'h0000_1008, lat);
    chk("after_rst_lat", lat, 2);
    chk("after_rst_data", cpu_data_o, 32'hDEADBEEF);
    chk("after_rst_hits", hit_cnt_o, 32'd1);
    chk("after_rst_misses", miss_cnt_o, 32'd0);
    chk("after_rst_txn_cnt", txn_q.size(), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
